// File: rtl/fourbit_alu_pkg.sv
// fourbit_alu_pkg: shared types and constants for the FourBitALU datapath
package fourbit_alu_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} mac_state_t;
  localparam int MAC_N_TERMS_DEF = 4;
  localparam int MAC_ACC_W_DEF = 10;
  localparam int PROD_W = 8;
endpackage

// File: rtl/fourbit_mac_if.sv
// fourbit_mac_if: operand-in and result-out valid/ready bundle of the MAC stage
interface fourbit_mac_if import fourbit_alu_pkg::*; #(parameter int ACC_W = MAC_ACC_W_DEF);
  logic in_valid;
  logic in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] acc_out;
  logic ovf;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, acc_out, ovf);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, acc_out, ovf);
endinterface

// File: rtl/fourbitMUL.sv
// fourbitMUL: combinational 4x4 unsigned array multiplier
module fourbitMUL (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) p = p + ({4'b0, a & {4{b[i]}}} << i);
  end
endmodule

// File: rtl/fourbit_mac.sv
// fourbit_mac: sums N_TERMS 4x4 products per result over valid/ready handshakes.
// Define FOURBIT_MAC_SATURATE_EN to clamp on overflow instead of wrapping.
module fourbit_mac import fourbit_alu_pkg::*; #(
  parameter int N_TERMS = MAC_N_TERMS_DEF,
  parameter int ACC_W = MAC_ACC_W_DEF
) (
  input logic clk,
  input logic rst_n,
  fourbit_mac_if.slave bus
);
  localparam int CNT_W = 5;
  mac_state_t state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic ovf, ovf_nx;
  logic [PROD_W-1:0] prod;
  logic [ACC_W:0] sum;
  logic accept;
  fourbitMUL u_mul (.a(bus.a), .b(bus.b), .p(prod));
  assign bus.in_ready = (state != DONE) || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign sum = {1'b0, acc} + (ACC_W+1)'(prod);
  assign bus.out_valid = state == DONE;
  assign bus.acc_out = acc;
  assign bus.ovf = ovf;
  // an accept outside ACCUM (IDLE, or DONE with output handshake) opens a new group
  always_comb begin
    state_nx = state;
    acc_nx = acc;
    cnt_nx = cnt;
    ovf_nx = ovf;
    if (accept && state == ACCUM) begin
      cnt_nx = cnt + 1'b1;
      ovf_nx = ovf | sum[ACC_W];
`ifdef FOURBIT_MAC_SATURATE_EN
      acc_nx = (ovf | sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
      acc_nx = sum[ACC_W-1:0];
`endif
      state_nx = (cnt == CNT_W'(N_TERMS - 1)) ? DONE : ACCUM;
    end else if (accept) begin
      acc_nx = ACC_W'(prod);
      cnt_nx = CNT_W'(1);
      ovf_nx = 1'b0;
      state_nx = (N_TERMS == 1) ? DONE : ACCUM;
    end else if (state == DONE && bus.out_ready) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nx;
      acc <= acc_nx;
      cnt <= cnt_nx;
      ovf <= ovf_nx;
    end
  end
endmodule

// File: tb/tb_fourbit_mac.sv
// tb_fourbit_mac: directed self-checking bench for fourbit_mac (ACC_W=10 and ACC_W=9 instances)
module tb_fourbit_mac;
  logic clk = 1'b0;
  logic rst_n;
  logic iv, ordy;
  logic [3:0] ra, rb;
  int checks = 0;
  int failures = 0;
`ifdef FOURBIT_MAC_SATURATE_EN
  localparam int OVF_ACC = 511;
`else
  localparam int OVF_ACC = 388;
`endif
  fourbit_mac_if #(.ACC_W(10)) bus_a ();
  fourbit_mac_if #(.ACC_W(9)) bus_b ();
  assign bus_a.in_valid = iv;
  assign bus_a.a = ra;
  assign bus_a.b = rb;
  assign bus_a.out_ready = ordy;
  assign bus_b.in_valid = iv;
  assign bus_b.a = ra;
  assign bus_b.b = rb;
  assign bus_b.out_ready = ordy;
  fourbit_mac #(.N_TERMS(4), .ACC_W(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  fourbit_mac #(.N_TERMS(4), .ACC_W(9)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y);
    iv = v;
    ra = x;
    rb = y;
    step();
  endtask
  logic [3:0] basic_a [4] = '{4'd3, 4'd2, 4'd15, 4'd0};
  logic [3:0] basic_b [4] = '{4'd5, 4'd7, 4'd15, 4'd9};
  logic [11:0] bub [7] = '{{4'd1, 4'd2, 4'd3}, 12'd0, {4'd1, 4'd4, 4'd4}, 12'd0, 12'd0,
                           {4'd1, 4'd1, 4'd5}, {4'd1, 4'd0, 4'd0}};
  initial begin
    iv = 0; ra = 0; rb = 0; ordy = 1; rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    chk("rst_in_ready", 32'(bus_a.in_ready), 1);
    chk("rst_out_valid", 32'(bus_a.out_valid), 0);
    chk("rst_acc_out", 32'(bus_a.acc_out), 0);
    chk("rst_ovf", 32'(bus_a.ovf), 0);
    for (int i = 0; i < 4; i++) begin
      chk("basic_busy", 32'(bus_a.out_valid), 0);
      drive(1, basic_a[i], basic_b[i]);
    end
    chk("basic_valid", 32'(bus_a.out_valid), 1);
    chk("basic_acc", 32'(bus_a.acc_out), 254);
    chk("basic_ovf", 32'(bus_a.ovf), 0);
    ordy = 0; iv = 1; ra = 1; rb = 1;
    #1 chk("bp_in_ready", 32'(bus_a.in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_ready", 32'(bus_a.in_ready), 0);
      chk("bp_hold_valid", 32'(bus_a.out_valid), 1);
      chk("bp_hold_acc", 32'(bus_a.acc_out), 254);
    end
    ordy = 1;
    #1 chk("bp_release_ready", 32'(bus_a.in_ready), 1);
    step();
    chk("bp_taken_valid", 32'(bus_a.out_valid), 0);
    chk("bp_taken_acc", 32'(bus_a.acc_out), 1);
    for (int k = 2; k <= 8; k++) begin
      step();
      chk("b2b_ready", 32'(bus_a.in_ready), 1);
      chk("b2b_valid", 32'(bus_a.out_valid), (k == 4 || k == 8) ? 1 : 0);
      if (k == 4 || k == 8) chk("b2b_acc", 32'(bus_a.acc_out), 4);
    end
    iv = 0;
    step();
    chk("b2b_drain", 32'(bus_a.out_valid), 0);
    for (int i = 0; i < 4; i++) drive(1, 15, 15);
    iv = 0; ordy = 0;
    chk("ovf10_acc", 32'(bus_a.acc_out), 900);
    chk("ovf10_flag", 32'(bus_a.ovf), 0);
    chk("ovf9_valid", 32'(bus_b.out_valid), 1);
    chk("ovf9_acc", 32'(bus_b.acc_out), OVF_ACC);
    chk("ovf9_flag", 32'(bus_b.ovf), 1);
    step();
    chk("ovf9_hold_acc", 32'(bus_b.acc_out), OVF_ACC);
    chk("ovf9_hold_flag", 32'(bus_b.ovf), 1);
    ordy = 1;
    step();
    chk("ovf_drain", 32'(bus_b.out_valid), 0);
    foreach (bub[i]) drive(bub[i][8], bub[i][7:4], bub[i][3:0]);
    iv = 0;
    chk("bub_valid", 32'(bus_a.out_valid), 1);
    chk("bub_acc", 32'(bus_a.acc_out), 27);
    chk("bub9_acc", 32'(bus_b.acc_out), 27);
    chk("bub9_ovf_cleared", 32'(bus_b.ovf), 0);
    step();
    drive(1, 15, 15);
    drive(1, 15, 15);
    iv = 0; rst_n = 0;
    step();
    rst_n = 1;
    chk("mrst_valid", 32'(bus_a.out_valid), 0);
    chk("mrst_acc", 32'(bus_a.acc_out), 0);
    chk("mrst_ovf", 32'(bus_a.ovf), 0);
    chk("mrst_ready", 32'(bus_a.in_ready), 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 2);
    iv = 0;
    chk("mrst_grp_valid", 32'(bus_a.out_valid), 1);
    chk("mrst_grp_acc", 32'(bus_a.acc_out), 8);
    chk("mrst_grp_ovf", 32'(bus_a.ovf), 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fourbit_mac.md
# fourbit_mac

Sequential multiply-accumulate stage directly downstream of the 4x4 array multiplier `fourbitMUL` in the FourBitALU datapath. It accepts a stream of 4-bit operand pairs over a valid/ready handshake and forms each 8-bit product with `fourbitMUL`. It sums `N_TERMS` consecutive products into an accumulator and presents the completed dot product on a valid/ready output port.

## Interface
- `N_TERMS`, default 4: products summed per result; legal range 1..16.
- `ACC_W`, default 10: accumulator and result width; legal range 8..16.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operand pair `a`/`b` is valid.
- `in_ready`  out  1  block accepts an operand pair this cycle.
- `a`  in  4  unsigned multiplicand.
- `b`  in  4  unsigned multiplier.
- `out_valid`  out  1  `acc_out` holds a completed result.
- `out_ready`  in  1  downstream consumes the result.
- `acc_out`  out  ACC_W  accumulated sum of `N_TERMS` products.
- `ovf`  out  1  result overflowed `ACC_W` bits; qualified by `out_valid`.

## Operation
- A term is accepted on a rising edge where `in_valid && in_ready`. The product is `a*b` from `fourbitMUL` and is zero-extended to `ACC_W`.
- `cnt` counts the terms accepted in the current group, from 0 to `N_TERMS`-1.
- State machine with three states:
  - IDLE: `in_ready`=1. On accept: `acc`<=product, `cnt`<=1, `ovf`<=0. Next state is DONE if `N_TERMS`==1, otherwise ACCUM.
  - ACCUM: `in_ready`=1. On accept: `acc`<=`acc`+product and `cnt`++. On the `N_TERMS`-th accept, next state is DONE.
  - DONE: `out_valid`=1 and `in_ready`=`out_ready`.
    - On output handshake with no new accept: next state IDLE.
    - On output handshake plus a simultaneous accept: a new group starts exactly as from IDLE, with no bubble cycle.
- Overflow: if any addition carries out of bit `ACC_W`-1, the group's `ovf` is set and stays sticky until the next group starts.
- `acc_out` and `ovf` are held stable throughout DONE while `out_ready`=0.
- Gaps in `in_valid` within a group are allowed and do not change the result.
- Reset values: state IDLE, `acc`=0, `cnt`=0, `ovf`=0, `out_valid`=0, `acc_out`=0. `in_ready` is 1 in the first cycle after reset.
- Reset mid-group discards the partial sum. The next group starts from zero.

## Timing
- `acc_out`, `ovf` and `out_valid` are registered. `out_valid` rises in the cycle after the `N_TERMS`-th accept.
- `in_ready` is combinational from state and `out_ready`. There is no path from `in_valid`, `a` or `b` to `in_ready`.
- The multiplier path is combinational within one cycle; the product is not pipelined.
- Throughput is one term per cycle. With `out_ready` held at 1, groups run back-to-back with no idle cycle.

## Configuration
- `FOURBIT_MAC_SATURATE_EN` defined: on overflow the accumulator clamps to all-ones (2^`ACC_W`-1) and stays clamped for the rest of the group. `ovf`=1.
- `FOURBIT_MAC_SATURATE_EN` undefined: the accumulator wraps modulo 2^`ACC_W`. `ovf`=1.

## Structure
- Shared package `fourbit_alu_pkg`:
  - typedef `mac_state_t` enum {IDLE, ACCUM, DONE};
  - constants `MAC_N_TERMS_DEF`=4 and `MAC_ACC_W_DEF`=10;
  - constant `PROD_W`=8.
- One sub-module: `fourbitMUL`, instantiated unchanged to produce the product.
- Everything else (state register, counter, accumulator, overflow logic) is written inline.

## Test plan
- Basic sum, defaults: pairs (3,5), (2,7), (15,15), (0,9) on consecutive cycles -> `out_valid` one cycle after the 4th accept, `acc_out`=254, `ovf`=0.
- Overflow, `ACC_W`=9: four pairs of (15,15) -> `acc_out`=388 and `ovf`=1 without the macro; `acc_out`=511 and `ovf`=1 with `FOURBIT_MAC_SATURATE_EN`.
- Backpressure: result 254 pending, `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, `acc_out`=254 held, no term consumed. `out_ready`=1 -> the held term is accepted in that same cycle.
- Back-to-back: `out_ready`=1 and a continuous stream of 8 pairs (1,1) -> two results of 4, with no idle cycle between groups.
- Bubbles: pairs (2,3), gap, (4,4), gap, gap, (1,5), (0,0) -> `acc_out`=27.
- Reset mid-group: accept (15,15) and (15,15), then assert `rst_n`=0 for 1 cycle -> all outputs 0. A following group of four pairs (1,2) -> `acc_out`=8.
